// File: rtl/ucsbece154b_icache_pkg.sv
// ucsbece154b_icache_pkg: shared FSM state encodings for the instruction cache
package ucsbece154b_icache_pkg;
  localparam logic icache_idle = 1'b0;
  localparam logic icache_refill = 1'b1;
endpackage

// File: rtl/ucsbece154b_icache_array.sv
// ucsbece154b_icache_array: valid/tag/data storage, async read, sync word and tag writes
module ucsbece154b_icache_array #(
  parameter int NUM_SETS = 8,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int IW = $clog2(NUM_SETS),
  parameter int OW = $clog2(WORDS_PER_BLOCK),
  parameter int TW = 30 - OW - IW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] rd_index,
  input  logic [OW-1:0] rd_word,
  output logic          rd_valid,
  output logic [TW-1:0] rd_tag,
  output logic [31:0]   rd_data,
  input  logic          wr_word_en,
  input  logic [IW-1:0] wr_index,
  input  logic [OW-1:0] wr_word,
  input  logic [31:0]   wr_data,
  input  logic          wr_tag_en,
  input  logic [TW-1:0] wr_tag
);
  logic [NUM_SETS-1:0] valid;
  logic [TW-1:0] tags [NUM_SETS];
  logic [31:0] data [NUM_SETS][WORDS_PER_BLOCK];
  always_ff @(posedge clk) begin
    if (reset) valid <= '0;
    else if (wr_tag_en) valid[wr_index] <= 1'b1;
  end
  always_ff @(posedge clk) begin
    if (wr_word_en) data[wr_index][wr_word] <= wr_data;
    if (wr_tag_en) tags[wr_index] <= wr_tag;
  end
  assign rd_valid = valid[rd_index];
  assign rd_tag = tags[rd_index];
  assign rd_data = data[rd_index][rd_word];
endmodule

// File: rtl/ucsbece154b_icache.sv
// ucsbece154b_icache: direct-mapped read-only icache with block refill and critical-word bypass
module ucsbece154b_icache import ucsbece154b_icache_pkg::*; #(
  parameter int NUM_SETS = 8,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PCF_i,
  input  logic        ReadEnable_i,
  output logic [31:0] InstrF_o,
  output logic        Ready_o,
  output logic        MemReadRequest_o,
  output logic [31:0] MemReadAddress_o,
  input  logic [31:0] MemDataIn_i,
  input  logic        MemDataReady_i
);
  localparam int OW = $clog2(WORDS_PER_BLOCK);
  localparam int IW = $clog2(NUM_SETS);
  localparam int TW = 30 - OW - IW;
  localparam int BO = 2 + OW;
  localparam logic [31:0] blk_mask = ~((32'd1 << BO) - 32'd1);
  logic state, state_next;
  logic [OW-1:0] count;
  logic req_pending;
  logic [31:0] miss_block_addr;
  logic rd_valid, hit, miss, beat, last, bypass;
  logic [TW-1:0] rd_tag;
  logic [31:0] rd_data;
  logic [OW-1:0] pc_word;
  logic [IW-1:0] pc_index, miss_index;
  logic [TW-1:0] pc_tag, miss_tag;
  assign pc_word = PCF_i[BO-1:2];
  assign pc_index = PCF_i[BO+IW-1:BO];
  assign pc_tag = PCF_i[31:BO+IW];
  assign miss_index = miss_block_addr[BO+IW-1:BO];
  assign miss_tag = miss_block_addr[31:BO+IW];
  ucsbece154b_icache_array #(
    .NUM_SETS(NUM_SETS),
    .WORDS_PER_BLOCK(WORDS_PER_BLOCK)
  ) u_array (
    .clk(clk),
    .reset(reset),
    .rd_index(pc_index),
    .rd_word(pc_word),
    .rd_valid(rd_valid),
    .rd_tag(rd_tag),
    .rd_data(rd_data),
    .wr_word_en(beat),
    .wr_index(miss_index),
    .wr_word(count),
    .wr_data(MemDataIn_i),
    .wr_tag_en(last),
    .wr_tag(miss_tag)
  );
  assign hit = (state == icache_idle) && ReadEnable_i && rd_valid && (rd_tag == pc_tag);
  assign miss = (state == icache_idle) && ReadEnable_i && !hit;
  assign beat = (state == icache_refill) && MemDataReady_i;
  assign last = beat && (count == OW'(WORDS_PER_BLOCK - 1));
  // serve the beat straight from memory only if it is exactly the word fetch is waiting on
  assign bypass = beat && ReadEnable_i && (count == pc_word) && ((PCF_i & blk_mask) == miss_block_addr);
  always_ff @(posedge clk) state <= reset ? icache_idle : state_next;
  always_comb state_next = miss ? icache_refill : last ? icache_idle : state;
  always_comb begin
    Ready_o = hit || bypass;
    InstrF_o = hit ? rd_data : bypass ? MemDataIn_i : 32'd0;
    MemReadRequest_o = req_pending;
    MemReadAddress_o = (state == icache_refill) ? miss_block_addr : 32'd0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      req_pending <= 1'b0;
      miss_block_addr <= 32'd0;
    end else if (miss) begin
      count <= '0;
      req_pending <= 1'b1;
      miss_block_addr <= PCF_i & blk_mask;
    end else if (beat) begin
      count <= count + 1'b1;
      req_pending <= 1'b0;
    end
  end
endmodule
